// File: rtl/stream_credit_scheduler_pkg.sv
// ============================================================================
// Module : sched_pkg
// Brief  : Shared FSM encoding, credit sizing and saturating add for the
//          stream credit scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sched_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    RESEND = 1'b1
  } sched_state_e;

  localparam int NUM_BRAM_ADDR_BITS_DEF = 7;
  localparam int CREDIT_W               = NUM_BRAM_ADDR_BITS_DEF + 1;
  localparam int CREDIT_MAX             = 2 ** NUM_BRAM_ADDR_BITS_DEF;

  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max);
    int unsigned sum;
    sum = a + b;
    return (sum > max) ? max : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_credit_scheduler_if.sv
// ============================================================================
// Module : stream_credit_scheduler_if
// Brief  : Bundles the request, packet and credit-return signals of the
//          scheduler; the scheduler itself attaches through the slave modport.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface stream_credit_scheduler_if #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_OUT_PORTS = 7,
  parameter int NUM_PORT_BITS = 4
);

  logic                                   resend;
  logic [NUM_IN_PORTS-1:0]                freespace_update;
  logic [PACKET_BITS*NUM_IN_PORTS-1:0]    packet_from_input_ports;
  logic [NUM_IN_PORTS-1:0]                update_ack;
  logic [NUM_OUT_PORTS-1:0]               empty;
  logic [PACKET_BITS*NUM_OUT_PORTS-1:0]   packet_from_output_ports;
  logic [NUM_OUT_PORTS-1:0]               rd_en_sel;
  logic                                   credit_ret_vld;
  logic [NUM_PORT_BITS-1:0]               credit_ret_port;
  logic [PACKET_BITS-1:0]                 stream_out;

  modport master (
    output resend, freespace_update, packet_from_input_ports, empty,
           packet_from_output_ports, credit_ret_vld, credit_ret_port,
    input  update_ack, rd_en_sel, stream_out
  );

  modport slave (
    input  resend, freespace_update, packet_from_input_ports, empty,
           packet_from_output_ports, credit_ret_vld, credit_ret_port,
    output update_ack, rd_en_sel, stream_out
  );

endinterface

`default_nettype wire

// File: rtl/stream_credit_scheduler_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; the first requester at or after
//          the pointer (wrapping) wins.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N     = 7,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (32'(ptr_i) + 32'(off)) % 32'(N);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PTR_W'(idx);
        gnt_vld_o  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_credit_scheduler.sv
// ============================================================================
// Module : stream_credit_scheduler
// Brief  : Picks the packet for the outbound BFT link: freespace updates first,
//          then credit-gated round-robin over output-port FIFOs. Define
//          SCHED_STALL_CNT_EN to add the stall_cnt output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stream_credit_scheduler
  import sched_pkg::*;
#(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_IN_PORTS          = 7,
  parameter int NUM_OUT_PORTS         = 7,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic        clk_bft,
  input  logic        reset_bft,
`ifdef SCHED_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  stream_credit_scheduler_if.slave bus
);

  localparam int CNT_W   = NUM_BRAM_ADDR_BITS + 1;
  localparam int CNT_MAX = 2 ** NUM_BRAM_ADDR_BITS;
  localparam int PTR_W   = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  localparam logic [0:0] S_RUN    = RUN;
  localparam logic [0:0] S_RESEND = RESEND;

  logic [0:0]             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PACKET_BITS-1:0] stream_q, stream_d;
  logic [CNT_W-1:0]       credit_q [NUM_OUT_PORTS];
  logic [CNT_W-1:0]       credit_d [NUM_OUT_PORTS];

  logic                     arb_en, live;
  logic [NUM_OUT_PORTS-1:0] req, zero_cr, gnt, rd_en;
  logic [PTR_W-1:0]         gnt_idx;
  logic                     gnt_vld, data_go;
  logic [NUM_IN_PORTS-1:0]  ack;
  logic [PACKET_BITS-1:0]   upd_pkt, dat_pkt;

  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (bus.resend) state_d = S_RESEND;
        else            arb_en  = 1'b1;
      end
      default: begin
        if (!bus.resend) begin
          state_d = S_RUN;
          arb_en  = 1'b1;
        end
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, even though acks are combinational.
  assign live = arb_en && reset_bft;

  always_comb begin
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      zero_cr[j] = (credit_q[j] == '0);
      req[j]     = !bus.empty[j] && !zero_cr[j];
    end
  end

  rr_arbiter #(.N(NUM_OUT_PORTS), .PTR_W(PTR_W)) u_rr (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign ack     = live ? (bus.freespace_update & (~bus.freespace_update + NUM_IN_PORTS'(1)))
                        : '0;
  assign data_go = live && (bus.freespace_update == '0) && gnt_vld;
  assign rd_en   = data_go ? gnt : '0;

  assign bus.update_ack = ack;
  assign bus.rd_en_sel  = rd_en;
  assign bus.stream_out = stream_q;

  always_comb begin
    upd_pkt = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (ack[i]) upd_pkt = bus.packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS];
    end
    dat_pkt = bus.packet_from_output_ports[32'(gnt_idx)*PACKET_BITS +: PACKET_BITS];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (!live)          stream_d = stream_q;
    else if (ack != '0) stream_d = upd_pkt;
    else if (data_go) begin
      stream_d = dat_pkt;
      ptr_d    = (gnt_idx == PTR_W'(NUM_OUT_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
    else                stream_d = '0;
  end

  // A grant and a return on the same port fold into one update; grant needs credit != 0.
  always_comb begin
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      credit_d[j] = credit_q[j] - {{(CNT_W-1){1'b0}}, rd_en[j]};
      if (bus.credit_ret_vld && (bus.credit_ret_port == NUM_PORT_BITS'(j))) begin
        credit_d[j] = CNT_W'(sat_add(32'(credit_d[j]), 32'(FREESPACE_UPDATE_SIZE),
                                     32'(CNT_MAX)));
      end
    end
  end

  always_ff @(posedge clk_bft or negedge reset_bft) begin
    if (!reset_bft) begin
      state_q  <= S_RUN;
      ptr_q    <= '0;
      stream_q <= '0;
      for (int j = 0; j < NUM_OUT_PORTS; j++) credit_q[j] <= CNT_W'(CNT_MAX);
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      stream_q <= stream_d;
      for (int j = 0; j < NUM_OUT_PORTS; j++) credit_q[j] <= credit_d[j];
    end
  end

`ifdef SCHED_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stalled;

  assign stalled   = live && ((~bus.empty & zero_cr) != '0) && (ack == '0) && !data_go;
  assign stall_cnt = stall_q;

  always_ff @(posedge clk_bft or negedge reset_bft) begin
    if (!reset_bft)                      stall_q <= '0;
    else if (stalled && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end
`endif

endmodule

`default_nettype wire
